ahb_sensor_poller: RTL and testbench
====================================

# ahb_sensor_poller

AHB-Lite master that periodically reads the four-word sensor register block (edge flags for fork and crank, then fork and pedal period counts) and presents each complete, consistent set of values as a snapshot on a valid/ready interface. It sits on the AHB-Lite bus as a master, with the sensor slave on the bus. It removes the need for the processor to poll the sensors in software, so the speed and cadence logic can consume snapshots directly.

## Interface
- BASE_ADDR, 32'h5000_0000, byte address of the sensor block; must be 16-byte aligned.
- POLL_PERIOD, 32768, cycles between automatic polls (1 s at 32768 Hz); legal range 8..2^32-1.
- HCLK  in  1  bus clock; all logic on its rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HADDR  out  32  transfer address.
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only.
- HWRITE  out  1  always 0.
- HSIZE  out  3  always 3'b010 (word).
- HBURST  out  3  always 3'b000 (SINGLE).
- HWDATA  out  32  always 0.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer-complete / wait-state indication.
- HRESP  in  1  error response.
- enable  in  1  enables automatic polling.
- start  in  1  single-cycle request for an immediate poll.
- snap_valid  out  1  snapshot available.
- snap_ready  in  1  consumer accepts the snapshot.
- fork_edge, crank_edge  out  1 each  a sensor edge occurred since the previous poll.
- fork_cnt, pedal_cnt  out  32 each  captured period counts.
- overrun  out  1  sticky; an unaccepted snapshot was overwritten.
- bus_error  out  1  sticky; a poll was aborted by HRESP.

## Operation
- **Period counter:**
  - While enable=1, the counter increments every cycle.
  - At POLL_PERIOD-1 it wraps to 0 and sets `pending`.
  - While enable=0, the counter is held at 0.
  - start=1 sets `pending` regardless of enable.
- **Pending requests:** `pending` is one deep. Requests that arrive while it is already set, or while a poll is in progress, merge into that single pending request.
- **Starting a poll:** the FSM leaves IDLE when `pending`=1 and clears `pending` in the same cycle.
- **FSM states:** IDLE, ADDR (issuing word i=0..3), LAST (data phase of word 3 only), ABORT.
- **Word order:** addresses are BASE_ADDR+0, +4, +8, +12, issued in that order as pipelined single NONSEQ reads with no idle cycles between them.
- **Pipelining:**
  - An address phase and the previous word's data phase advance together, and only on a rising edge with HREADY=1.
  - While HREADY=0, all master outputs are held.
- **Data capture:** word data is captured into shadow registers on the edge that completes its data phase.
  - word0: fork_edge_shadow = ~HRDATA[0]
  - word1: crank_edge_shadow = ~HRDATA[0]
  - word2: fork_cnt
  - word3: pedal_cnt
- **Poll completion:** when word 3 completes, the shadows are copied to the outputs and snap_valid is set.
  - If snap_valid was already 1 and snap_ready=0 on that edge, the outputs are overwritten and overrun is set.
- **Handshake:**
  - snap_valid clears on any edge where snap_valid=1 and snap_ready=1 and no new snapshot is loaded.
  - If a load and an accept occur on the same edge, snap_valid stays 1 and overrun is not set.
- **Error response:**
  - HRESP=1 with HREADY=0 in a data phase: drive HTRANS=IDLE on the next cycle, which cancels the outstanding address, and go to ABORT.
  - In ABORT, wait for the second error cycle (HREADY=1), then set bus_error and return to IDLE.
  - Snapshot outputs and snap_valid are unchanged by an aborted poll.
- **Sticky flags:** overrun and bus_error clear only on HRESET.
- **Reset:** HRESET mid-poll returns the FSM to IDLE immediately, with no completion of the outstanding transfer.

## Timing
- **Reset values:**
  - HTRANS=IDLE, HADDR=BASE_ADDR, HWRITE=0, HSIZE=3'b010, HBURST=0, HWDATA=0.
  - snap_valid=0, fork_edge=0, crank_edge=0, fork_cnt=0, pedal_cnt=0, overrun=0, bus_error=0.
  - Counter=0, pending=0.
- **Zero-wait-state poll:** with `pending` set at edge E0:
  - cycle 1 drives word0 address.
  - Cycles 2-4 drive words 1-3, each alongside the previous word's data phase.
  - Cycle 5 drives HTRANS=IDLE during the word3 data phase.
  - snap_valid=1 after edge E5.
  - Total 5 bus cycles; the next poll can issue its first address in cycle 6.
- **Wait states:** each HREADY=0 cycle adds exactly one cycle to the poll.
- **Automatic poll spacing:** with enable held high, first addresses of successive polls are exactly POLL_PERIOD cycles apart (absent wait states exceeding POLL_PERIOD-5).
- **Idle bus:** HTRANS=IDLE in every cycle outside ADDR; HADDR may hold its last value.

## Test plan
- **Zero-wait poll:** reset; slave returns 0, 1, 0x1234, 0x0800 with HREADY=1; pulse start -> HADDR sequence 0x5000_0000/04/08/0C in consecutive cycles; snap_valid=1 five cycles after start is sampled; fork_edge=1, crank_edge=0, fork_cnt=0x1234, pedal_cnt=0x0800.
- **Wait states:** insert 2 wait cycles on the word2 data phase -> HADDR and HTRANS held during the waits; snapshot after 7 cycles with correct values.
- **Periodic polling:** enable=1, POLL_PERIOD=16 -> NONSEQ to 0x5000_0000 every 16 cycles; enable=0 -> no further transfers.
- **Overrun and simultaneous accept:**
  - Keep snap_ready=0 across two polls -> second snapshot data visible, overrun=1.
  - Reset, then assert snap_ready on the completion edge -> snap_valid stays 1, overrun=0.
- **Error abort:** two-cycle HRESP on word1 -> HTRANS=IDLE in the cycle after the first error cycle; bus_error=1; prior snapshot and snap_valid unchanged; the next start performs a full poll.
- **Reset mid-poll:** assert HRESET during the word2 address phase -> all outputs at reset values that cycle; the poll does not resume after reset release.

Source files
------------

// File: rtl/ahb_sensor_poller.sv
// rtl/ahb_sensor_poller.sv - AHB-Lite master that polls a four-word sensor block
// and offers each complete set of readings as a valid/ready snapshot.
module ahb_sensor_poller #(
    parameter logic [31:0] BASE_ADDR   = 32'h5000_0000,
    parameter logic [31:0] POLL_PERIOD = 32'd32768
) (
    input  logic        HCLK,
    input  logic        HRESET,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic        enable,
    input  logic        start,
    output logic        snap_valid,
    input  logic        snap_ready,
    output logic        fork_edge,
    output logic        crank_edge,
    output logic [31:0] fork_cnt,
    output logic [31:0] pedal_cnt,
    output logic        overrun,
    output logic        bus_error
);

    localparam logic [31:0] PERIOD_LAST = POLL_PERIOD - 32'd1;
    localparam logic [1:0]  TRANS_IDLE   = 2'b00;
    localparam logic [1:0]  TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_LAST,
        S_ABORT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  idx;
    logic [1:0]  idx_nxt;

    logic [31:0] period_cnt;
    logic        pending;
    logic        wrap;
    logic        req;
    logic        go;
    logic        capture;
    logic        complete;
    logic        abort_done;
    logic [1:0]  data_word;

    logic        fork_edge_shadow;
    logic        crank_edge_shadow;
    logic [31:0] fork_cnt_shadow;

    assign wrap = enable && (period_cnt == PERIOD_LAST);
    assign req  = start | wrap;

    // Address phase is purely a function of the FSM registers, so holding the
    // FSM during wait states holds every master output.
    assign HTRANS = (state == S_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR  = BASE_ADDR + {28'd0, idx, 2'b00};
    assign HWRITE = 1'b0;
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;
    assign HWDATA = 32'd0;

    // While issuing word i the bus is in the data phase of word i-1; in LAST
    // idx stays at 3 and the data phase belongs to word 3.
    assign data_word = (state == S_LAST) ? idx : idx - 2'd1;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= S_IDLE;
            idx   <= 2'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        go         = 1'b0;
        capture    = 1'b0;
        complete   = 1'b0;
        abort_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending || req) begin
                    go        = 1'b1;
                    state_nxt = S_ADDR;
                    idx_nxt   = 2'd0;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    capture = (idx != 2'd0);
                    if (idx == 2'd3) begin
                        state_nxt = S_LAST;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end else if (HRESP && (idx != 2'd0)) begin
                    state_nxt = S_ABORT;
                end
            end
            S_LAST: begin
                if (HREADY) begin
                    capture  = 1'b1;
                    complete = 1'b1;
                    // Back-to-back polls skip IDLE so the next first address
                    // follows the final data phase directly.
                    if (pending || req) begin
                        go        = 1'b1;
                        state_nxt = S_ADDR;
                        idx_nxt   = 2'd0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (HRESP) begin
                    state_nxt = S_ABORT;
                end
            end
            S_ABORT: begin
                if (HREADY) begin
                    abort_done = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            period_cnt <= 32'd0;
        end else if (!enable || wrap) begin
            period_cnt <= 32'd0;
        end else begin
            period_cnt <= period_cnt + 32'd1;
        end
    end

    // One-deep request latch; a request seen on a launch edge is consumed by it.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pending <= 1'b0;
        end else if (go) begin
            pending <= 1'b0;
        end else if (req) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            fork_edge_shadow  <= 1'b0;
            crank_edge_shadow <= 1'b0;
            fork_cnt_shadow   <= 32'd0;
        end else if (capture) begin
            case (data_word)
                2'd0:    fork_edge_shadow  <= ~HRDATA[0];
                2'd1:    crank_edge_shadow <= ~HRDATA[0];
                2'd2:    fork_cnt_shadow   <= HRDATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            snap_valid <= 1'b0;
            fork_edge  <= 1'b0;
            crank_edge <= 1'b0;
            fork_cnt   <= 32'd0;
            pedal_cnt  <= 32'd0;
            overrun    <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            if (complete) begin
                fork_edge  <= fork_edge_shadow;
                crank_edge <= crank_edge_shadow;
                fork_cnt   <= fork_cnt_shadow;
                pedal_cnt  <= HRDATA;
                snap_valid <= 1'b1;
                if (snap_valid && !snap_ready) begin
                    overrun <= 1'b1;
                end
            end else if (snap_valid && snap_ready) begin
                snap_valid <= 1'b0;
            end
            if (abort_done) begin
                bus_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_sensor_poller.sv
// tb/tb_ahb_sensor_poller.sv - self-checking bench for ahb_sensor_poller with a
// pipelined AHB slave model and a snapshot/handshake reference model.
module tb_ahb_sensor_poller;

    localparam logic [31:0] BASE   = 32'h5000_0000;
    localparam int          PERIOD = 16;
    localparam logic [1:0]  NSQ    = 2'b10;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        enable;
    logic        start;
    logic        snap_valid;
    logic        snap_ready;
    logic        fork_edge;
    logic        crank_edge;
    logic [31:0] fork_cnt;
    logic [31:0] pedal_cnt;
    logic        overrun;
    logic        bus_error;

    always #5 HCLK = ~HCLK;

    ahb_sensor_poller #(.BASE_ADDR(BASE), .POLL_PERIOD(32'd16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .enable(enable),
        .start(start), .snap_valid(snap_valid), .snap_ready(snap_ready),
        .fork_edge(fork_edge), .crank_edge(crank_edge), .fork_cnt(fork_cnt),
        .pedal_cnt(pedal_cnt), .overrun(overrun), .bus_error(bus_error)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // slave model
    logic [31:0] mem [4];
    bit          dp_valid;
    logic [1:0]  dp_word;
    int          wait_left, err_phase, wait_word, wait_n, err_word;
    assign HRDATA = mem[dp_word];

    // snapshot reference model
    int          done_cyc;
    bit          m_valid, m_ovr, m_fe, m_ce, n_fe, n_ce;
    logic [31:0] m_fc, m_pc, n_fc, n_pc;

    typedef struct {
        logic [31:0] w0, w1, w2, w3;
        int          wword, wn;
        logic        fe, ce;
        logic [31:0] fc, pc;
        int          lat;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_slave();
        if (dp_valid && err_phase == 1) begin
            HREADY = 1'b0; HRESP = 1'b1;
        end else if (dp_valid && err_phase == 2) begin
            HREADY = 1'b1; HRESP = 1'b1;
        end else if (dp_valid && wait_left > 0) begin
            HREADY = 1'b0; HRESP = 1'b0;
        end else begin
            HREADY = 1'b1; HRESP = 1'b0;
        end
    endtask

    task automatic tick();
        logic [1:0]  p_trans;
        logic [31:0] p_addr;
        logic        p_ready, p_sr;
        p_trans = HTRANS; p_addr = HADDR; p_ready = HREADY; p_sr = snap_ready;
        @(posedge HCLK);
        #1;
        cyc++;
        if (p_ready) begin
            if (err_phase == 2) begin
                err_phase = 0;
                err_word  = -1;
            end
            dp_valid = (p_trans == NSQ);
            if (dp_valid) begin
                dp_word = p_addr[3:2];
                if (err_word == int'(dp_word)) err_phase = 1;
                else if (wait_word == int'(dp_word)) wait_left = wait_n;
                else wait_left = 0;
            end
        end else begin
            if (err_phase == 1) err_phase = 2;
            else if (wait_left > 0) wait_left--;
        end
        drive_slave();
        if (cyc == done_cyc) begin
            if (m_valid && !p_sr) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_fe = n_fe; m_ce = n_ce; m_fc = n_fc; m_pc = n_pc;
        end else if (m_valid && p_sr) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_htrans"}, {30'd0, HTRANS}, 32'd0);
        check({tag, "_haddr"}, HADDR, BASE);
        check({tag, "_hwrite"}, {31'd0, HWRITE}, 32'd0);
        check({tag, "_hsize"}, {29'd0, HSIZE}, 32'd2);
        check({tag, "_hburst"}, {29'd0, HBURST}, 32'd0);
        check({tag, "_hwdata"}, HWDATA, 32'd0);
        check({tag, "_snap_valid"}, {31'd0, snap_valid}, 32'd0);
        check({tag, "_fork_edge"}, {31'd0, fork_edge}, 32'd0);
        check({tag, "_crank_edge"}, {31'd0, crank_edge}, 32'd0);
        check({tag, "_fork_cnt"}, fork_cnt, 32'd0);
        check({tag, "_pedal_cnt"}, pedal_cnt, 32'd0);
        check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        check({tag, "_bus_error"}, {31'd0, bus_error}, 32'd0);
    endtask

    task automatic do_reset(input bit chk, input string tag);
        HRESET = 1'b1;
        start = 1'b0; enable = 1'b0; snap_ready = 1'b0;
        dp_valid = 1'b0; dp_word = 2'd0; wait_left = 0; err_phase = 0;
        wait_word = -1; wait_n = 0; err_word = -1;
        drive_slave();
        m_valid = 1'b0; m_ovr = 1'b0; done_cyc = -1;
        #2;
        if (chk) check_reset(tag);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    task automatic set_mem(input logic [31:0] a, b, c, d);
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
    endtask

    task automatic do_poll();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, last, hits, idle_hits;
        logic [1:0]  q_trans[$];
        logic [31:0] q_addr[$];

        set_mem(32'd0, 32'd0, 32'd0, 32'd0);
        do_reset(1'b1, "rst");

        vecs[0] = '{32'h0, 32'h1, 32'h1234, 32'h0800, -1, 0, 1'b1, 1'b0, 32'h1234, 32'h0800, 5};
        vecs[1] = '{32'h3, 32'h2, 32'hDEAD_BEEF, 32'h1, 2, 2, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1, 7};
        vecs[2] = '{32'hFFFF_FFFE, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 0, 1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 6};
        vecs[3] = '{32'h1, 32'h1, 32'hFF, 32'h1234_5678, 3, 3, 1'b0, 1'b0, 32'hFF, 32'h1234_5678, 8};

        for (int v = 0; v < 4; v++) begin
            set_mem(vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].w3);
            wait_word = vecs[v].wword;
            wait_n    = vecs[v].wn;
            q_trans.delete();
            q_addr.delete();
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 1 + ((i > 0 && wait_word == i - 1) ? wait_n : 0); k++) begin
                    q_trans.push_back(NSQ);
                    q_addr.push_back(BASE + 32'(4 * i));
                end
            end
            for (int k = 0; k < 1 + ((wait_word == 3) ? wait_n : 0); k++) begin
                q_trans.push_back(2'b00);
                q_addr.push_back(BASE);
            end
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 1;
            while (!snap_valid && n <= 20) begin
                if (n <= q_trans.size()) begin
                    check($sformatf("v%0d_htrans_c%0d", v, n), {30'd0, HTRANS}, {30'd0, q_trans[n-1]});
                    if (q_trans[n-1] == NSQ)
                        check($sformatf("v%0d_haddr_c%0d", v, n), HADDR, q_addr[n-1]);
                end
                tick();
                n++;
            end
            check($sformatf("v%0d_latency", v), 32'(n - 1), 32'(vecs[v].lat));
            check($sformatf("v%0d_latency_model", v), 32'(n - 1), 32'(q_trans.size()));
            check($sformatf("v%0d_idle_after", v), {30'd0, HTRANS}, 32'd0);
            check($sformatf("v%0d_fork_edge", v), {31'd0, fork_edge}, {31'd0, vecs[v].fe});
            check($sformatf("v%0d_crank_edge", v), {31'd0, crank_edge}, {31'd0, vecs[v].ce});
            check($sformatf("v%0d_fork_cnt", v), fork_cnt, vecs[v].fc);
            check($sformatf("v%0d_pedal_cnt", v), pedal_cnt, vecs[v].pc);
            snap_ready = 1'b1;
            tick();
            snap_ready = 1'b0;
            check($sformatf("v%0d_accept", v), {31'd0, snap_valid}, 32'd0);
        end
        check("table_overrun", {31'd0, overrun}, 32'd0);

        // periodic polling
        do_reset(1'b0, "");
        set_mem(32'd0, 32'd0, 32'd5, 32'd6);
        snap_ready = 1'b1;
        enable = 1'b1;
        last = -1;
        hits = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (HTRANS == NSQ && HADDR == BASE) begin
                if (last >= 0) check("poll_spacing", 32'(cyc - last), 32'(PERIOD));
                last = cyc;
                hits++;
            end
        end
        check("poll_count_ge4", {31'd0, hits >= 4}, 32'd1);
        enable = 1'b0;
        repeat (8) tick();
        idle_hits = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (HTRANS == NSQ) idle_hits++;
        end
        check("disabled_no_transfers", 32'(idle_hits), 32'd0);
        snap_ready = 1'b0;

        // overrun
        do_reset(1'b0, "");
        set_mem(32'd0, 32'd0, 32'd1, 32'd2);
        do_poll();
        check("ovr_first_valid", {31'd0, snap_valid}, 32'd1);
        check("ovr_first_flag", {31'd0, overrun}, 32'd0);
        set_mem(32'd1, 32'd1, 32'd3, 32'd4);
        do_poll();
        check("ovr_valid", {31'd0, snap_valid}, 32'd1);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_fork_cnt", fork_cnt, 32'd3);
        check("ovr_pedal_cnt", pedal_cnt, 32'd4);
        check("ovr_fork_edge", {31'd0, fork_edge}, 32'd0);

        // load and accept on the same edge
        do_reset(1'b0, "");
        set_mem(32'd0, 32'd0, 32'd1, 32'd2);
        do_poll();
        set_mem(32'd1, 32'd1, 32'd3, 32'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        check("sim_valid", {31'd0, snap_valid}, 32'd1);
        check("sim_overrun", {31'd0, overrun}, 32'd0);
        check("sim_pedal_cnt", pedal_cnt, 32'd4);
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        check("sim_accept", {31'd0, snap_valid}, 32'd0);

        // error abort on word 1
        do_poll();
        set_mem(32'd0, 32'd0, 32'h55, 32'h66);
        err_word = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("err_c3_htrans", {30'd0, HTRANS}, {30'd0, NSQ});
        check("err_c3_haddr", HADDR, BASE + 32'd8);
        tick();
        check("err_c4_htrans_idle", {30'd0, HTRANS}, 32'd0);
        tick();
        check("err_bus_error", {31'd0, bus_error}, 32'd1);
        check("err_snap_valid", {31'd0, snap_valid}, 32'd1);
        check("err_pedal_cnt", pedal_cnt, 32'd4);
        check("err_fork_cnt", fork_cnt, 32'd3);
        repeat (3) tick();
        do_poll();
        check("err_retry_fork_cnt", fork_cnt, 32'h55);
        check("err_retry_pedal_cnt", pedal_cnt, 32'h66);
        check("err_retry_fork_edge", {31'd0, fork_edge}, 32'd1);
        check("err_sticky", {31'd0, bus_error}, 32'd1);

        // reset during the word2 address phase
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        do_reset(1'b1, "midrst");
        idle_hits = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (HTRANS == NSQ) idle_hits++;
        end
        check("midrst_no_resume", 32'(idle_hits), 32'd0);

        // randomized polls against the snapshot model
        do_reset(1'b0, "");
        for (int it = 0; it < 25; it++) begin
            set_mem($urandom, $urandom, $urandom, $urandom);
            wait_word = int'($urandom_range(0, 3));
            wait_n    = int'($urandom_range(0, 3));
            n_fe = ~mem[0][0];
            n_ce = ~mem[1][0];
            n_fc = mem[2];
            n_pc = mem[3];
            done_cyc = cyc + 1 + 5 + wait_n;
            snap_ready = 1'($urandom_range(0, 1));
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 5 + wait_n + int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++) begin
                snap_ready = 1'($urandom_range(0, 1));
                tick();
                check("rnd_snap_valid", {31'd0, snap_valid}, {31'd0, m_valid});
                check("rnd_overrun", {31'd0, overrun}, {31'd0, m_ovr});
                if (m_valid) begin
                    check("rnd_fork_edge", {31'd0, fork_edge}, {31'd0, m_fe});
                    check("rnd_crank_edge", {31'd0, crank_edge}, {31'd0, m_ce});
                    check("rnd_fork_cnt", fork_cnt, m_fc);
                    check("rnd_pedal_cnt", pedal_cnt, m_pc);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
